clint_timer: RTL and testbench



---
 rtl/clint_timer.sv | 169 ++++++++++++++++
 tb/tb_clint_timer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clint_timer.sv
// clint_timer: core-local interruptor in the CLINT window.
// Holds msip, the 64-bit mtime counter and the 64-bit mtimecmp register.
// It derives the RTC tick from the system clock and drives the machine
// timer and software interrupt lines.
//
// Build option:
//   CLINT_MTIME_WR_EN - when defined, mtime (0xBFF8/0xBFFC) is byte-writable.
//                       A write wins over a coincident tick.
//                       When undefined, mtime writes are acknowledged but ignored.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   mem_valid           request valid, held until mem_ready
//   mem_instr           fetch flag (ignored)
//   mem_addr/wdata      byte address / write data
//   mem_wstrb           byte write strobes, 0000 = read
//   mem_rdata           read data, nonzero only while mem_ready=1
//   mem_ready           one-cycle completion pulse
//   timer_irq           machine timer interrupt (mtime >= mtimecmp)
//   soft_irq            machine software interrupt (msip[0])
module clint_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned RTC_DIV   = 1524
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        timer_irq,
  output logic        soft_irq
);

  localparam int unsigned DIV_W = (RTC_DIV > 0) ? $clog2(RTC_DIV + 1) : 1;

  localparam logic [31:0] OFF_MSIP     = 32'h0000_0000;
  localparam logic [31:0] OFF_MTCMP_LO = 32'h0000_4000;
  localparam logic [31:0] OFF_MTCMP_HI = 32'h0000_4004;
  localparam logic [31:0] OFF_MTIME_LO = 32'h0000_BFF8;
  localparam logic [31:0] OFF_MTIME_HI = 32'h0000_BFFC;

  typedef enum logic {IDLE, RESP} state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic               phase;
  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic               msip;

  logic [31:0]        offset;
  logic               accept;
  logic               wr;
  logic               div_wrap;
  logic               tick;
  logic [31:0]        rd_val;
  logic               unused_instr;

  assign unused_instr = mem_instr;

  // Lane-wise merge of write data into an existing 32-bit word.
  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] data,
                                        input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

  // Request decode and read mux from the current (pre-edge) register values.
  always_comb begin
    offset   = mem_addr - BASE_ADDR;
    accept   = (state == IDLE) && mem_valid;
    wr       = |mem_wstrb;
    div_wrap = (div_cnt == DIV_W'(RTC_DIV));
    tick     = div_wrap && !phase;
    rd_val   = 32'h0;
    case (offset)
      OFF_MSIP:     rd_val = {31'h0, msip};
      OFF_MTCMP_LO: rd_val = mtimecmp[31:0];
      OFF_MTCMP_HI: rd_val = mtimecmp[63:32];
      OFF_MTIME_LO: rd_val = mtime[31:0];
      OFF_MTIME_HI: rd_val = mtime[63:32];
      default:      rd_val = 32'h0;
    endcase
  end

  // Bus handshake: sample in IDLE, pulse mem_ready for one cycle in RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'h0;
      case (state)
        IDLE: begin
          if (mem_valid) begin
            state     <= RESP;
            mem_ready <= 1'b1;
            mem_rdata <= rd_val;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RTC divider; the tick is the edge where phase goes 0 -> 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      phase   <= ~phase;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // mtime counter; a write to either half suppresses that cycle's increment.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime <= 64'h0;
`ifdef CLINT_MTIME_WR_EN
    end else if (accept && wr && (offset == OFF_MTIME_LO)) begin
      mtime[31:0] <= merge(mtime[31:0], mem_wdata, mem_wstrb);
    end else if (accept && wr && (offset == OFF_MTIME_HI)) begin
      mtime[63:32] <= merge(mtime[63:32], mem_wdata, mem_wstrb);
`endif
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp and msip registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip     <= 1'b0;
    end else if (accept && wr) begin
      if (offset == OFF_MTCMP_LO) mtimecmp[31:0]  <= merge(mtimecmp[31:0], mem_wdata, mem_wstrb);
      if (offset == OFF_MTCMP_HI) mtimecmp[63:32] <= merge(mtimecmp[63:32], mem_wdata, mem_wstrb);
      if ((offset == OFF_MSIP) && mem_wstrb[0]) msip <= mem_wdata[0];
    end
  end

  // Interrupt lines lag the registers by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_irq <= 1'b0;
      soft_irq  <= 1'b0;
    end else begin
      timer_irq <= (mtime >= mtimecmp);
      soft_irq  <= msip;
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: a stimulus sequence queues expected read data and a
// monitor pops and compares on every mem_ready pulse.
// The tick model is that mtime increments at posedge 1525 + 3050*k after reset.
module tb_clint_timer;

  localparam logic [31:0] BASE = 32'h0200_0000;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        timer_irq;
  logic        soft_irq;

  int          n_vec;
  int          n_err;
  int          cyc;
  exp_t        exp_q[$];

  clint_timer #(.BASE_ADDR(BASE), .RTC_DIV(1524)) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_instr (mem_instr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .timer_irq (timer_irq),
    .soft_irq  (soft_irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Posedges since reset release, aligned with the DUT's divider.
  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=%08h req=%08h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare read data on each mem_ready pulse and enforce the handshake.
  task automatic monitor();
    logic prev_ready;
    exp_t e;
    prev_ready = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_ready = 1'b0;
      end else begin
        if (mem_ready) begin
          if (prev_ready) check("ready_back_to_back", 32'(mem_ready), 32'h0);
          if (exp_q.size() == 0) begin
            check("unexpected_ready", 32'(mem_ready), 32'h0);
          end else begin
            e = exp_q.pop_front();
            if (e.chk) check("rdata", mem_rdata, e.data);
          end
        end else if (prev_ready) begin
          check("rdata_idle_zero", mem_rdata, 32'h0);
        end
        prev_ready = mem_ready;
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clock);
  endtask

  // One request; returns at the negedge after the sampling edge.
  task automatic bus(input logic [31:0] off, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic chk, input logic [31:0] exp);
    @(negedge clock);
    mem_valid = 1'b1;
    mem_addr  = BASE + off;
    mem_wdata = wdata;
    mem_wstrb = strb;
    exp_q.push_back('{chk, exp});
    @(posedge clock);
    @(negedge clock);
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic rd(input logic [31:0] off, input logic [31:0] exp);
    bus(off, 32'h0, 4'h0, 1'b1, exp);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] strb);
    bus(off, data, strb, 1'b0, 32'h0);
  endtask

  // Request whose sampling edge is posedge number t.
  task automatic wr_at(input int t, input logic [31:0] off, input logic [31:0] data,
                       input logic [3:0] strb);
    wait_cyc(t - 2);
    if (cyc != t - 2) check("wr_at_alignment", 32'(cyc), 32'(t - 2));
    wr(off, data, strb);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    fork
      monitor();
    join_none

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_ready", 32'(mem_ready), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_timer_irq", 32'(timer_irq), 32'h0);
    check("rst_soft_irq", 32'(soft_irq), 32'h0);
    reset = 1'b0;

    // 1: two ticks (posedges 1525 and 4575) by cycle 6100
    wait_cyc(6100);
    rd(32'hBFF8, 32'h2);
    rd(32'hBFFC, 32'h0);
    check("t1_timer_irq", 32'(timer_irq), 32'h0);

    // 3: software interrupt
    wr(32'h0000, 32'hFFFF_FFFF, 4'hF);
    check("t3_soft_lag", 32'(soft_irq), 32'h0);
    @(negedge clock);
    check("t3_soft_set", 32'(soft_irq), 32'h1);
    rd(32'h0000, 32'h1);
    wr(32'h0000, 32'h0, 4'hF);
    check("t3_soft_hold", 32'(soft_irq), 32'h1);
    @(negedge clock);
    check("t3_soft_clr", 32'(soft_irq), 32'h0);

    // 4: continuous mem_valid gives ready every other cycle; unmapped reads 0
    @(negedge clock);
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h1234;
    mem_wstrb = 4'h0;
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b1, 32'h0});
    repeat (8) @(posedge clock);
    #1 mem_valid = 1'b0;

    // 2: mtimecmp = 5; mtime reaches 5 at posedge 13725
    wr(32'h4000, 32'h5, 4'hF);
    wr(32'h4004, 32'h0, 4'hF);
    rd(32'h4000, 32'h5);
    wait_cyc(13725);
    check("t2_irq_lag", 32'(timer_irq), 32'h0);
    @(negedge clock);
    check("t2_irq_rise", 32'(timer_irq), 32'h1);
    wr(32'h4004, 32'h1, 4'hF);
    check("t2_irq_hold", 32'(timer_irq), 32'h1);
    @(negedge clock);
    check("t2_irq_fall", 32'(timer_irq), 32'h0);

    // 5: mtime writes, write over a tick at posedge 16775, then wrap
    wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    wr(32'hBFFC, 32'hFFFF_FFFF, 4'hF);
    wr_at(16775, 32'hBFF8, 32'h0000_0010, 4'h1);
`ifdef CLINT_MTIME_WR_EN
    rd(32'hBFF8, 32'hFFFF_FF10);
    rd(32'hBFFC, 32'hFFFF_FFFF);
    wait_cyc(19826);
    rd(32'hBFF8, 32'hFFFF_FF11);
    wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    rd(32'hBFF8, 32'hFFFF_FFFF);
    wait_cyc(22876);
    rd(32'hBFF8, 32'h0);
    rd(32'hBFFC, 32'h0);
`else
    rd(32'hBFF8, 32'h6);
    rd(32'hBFFC, 32'h0);
    wait_cyc(19826);
    rd(32'hBFF8, 32'h7);
    wr(32'hBFF8, 32'hFFFF_FFFF, 4'hF);
    rd(32'hBFF8, 32'h7);
    wait_cyc(22876);
    rd(32'hBFF8, 32'h8);
    rd(32'hBFFC, 32'h0);
`endif

    // 6: reset asserted while a request is pending in IDLE
    wr(32'h0000, 32'h1, 4'h1);
    @(negedge clock);
    check("t6_soft_pre", 32'(soft_irq), 32'h1);
    @(negedge clock);
    mem_valid = 1'b1;
    mem_addr  = BASE + 32'h4000;
    mem_wstrb = 4'h0;
    #1 reset = 1'b1;
    #1;
    check("t6_rst_ready", 32'(mem_ready), 32'h0);
    check("t6_rst_soft", 32'(soft_irq), 32'h0);
    check("t6_rst_timer", 32'(timer_irq), 32'h0);
    repeat (3) @(negedge clock);
    mem_valid = 1'b0;
    reset     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t6_no_ready", 32'(mem_ready), 32'h0);
    end
    rd(32'h4000, 32'hFFFF_FFFF);
    rd(32'h4004, 32'hFFFF_FFFF);
    rd(32'hBFF8, 32'h0);
    rd(32'hBFFC, 32'h0);
    rd(32'h0000, 32'h0);

    repeat (4) @(negedge clock);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
